// File: rtl/rr_grant_mux.sv
// rr_grant_mux: four-client holding slots feeding a round-robin arbiter,
// with the granted slot forwarded to one shared valid/ready output channel.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_data  per-client handshake inputs (client i at [i*DATA_W +: DATA_W])
//   in_ready          per-client slot free (held low while rst is high)
//   req               request vector to the arbiter (occupied slots, ARB only)
//   grant             one-hot grant from the arbiter
//   out_valid/out_data/out_src/out_ready  shared output channel
//   err_grant         sticky illegal-grant flag
//   grant_cnt         per-client 8-bit saturating handshake counters
//                     (built only with RR_MUX_CNT_EN, otherwise tied to 0)
//
// Build option: define RR_MUX_CNT_EN to build the grant counters.

module rr_grant_mux #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic [3:0]          req,
    input  logic [3:0]          grant,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_src,
    input  logic                out_ready,
    output logic                err_grant,
    output logic [31:0]         grant_cnt
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [3:0]        full_q;
    logic [3:0]        full_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [1:0]        src_q;
    logic [1:0]        src_d;
    logic              err_q;
    logic              err_d;

    logic [3:0] load;
    logic       hs;
    logic       in_arb;

    logic       g_zero;
    logic       g_onehot;
    logic       g_hit;
    logic       g_legal;
    logic [1:0] g_idx;

    // ------------------------------------------------------------------
    // Grant qualification
    // ------------------------------------------------------------------
    assign in_arb   = (state_q == ST_ARB);
    assign g_zero   = (grant == 4'd0);
    assign g_onehot = !g_zero && ((grant & (grant - 4'd1)) == 4'd0);
    assign g_hit    = |(grant & full_q);
    assign g_legal  = g_onehot && g_hit;

    // Multi-hot grants reach this encoder too; they are rejected by
    // g_legal, so only the lowest set bit matters here.
    always_comb begin
        g_idx = 2'd0;
        priority case (1'b1)
            grant[0]: g_idx = 2'd0;
            grant[1]: g_idx = 2'd1;
            grant[2]: g_idx = 2'd2;
            grant[3]: g_idx = 2'd3;
            default:  g_idx = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (g_legal) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Dropping req in SEND freezes the arbiter until the output drains.
    always_comb begin
        req       = 4'd0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = 2'd0;
        case (state_q)
            ST_ARB: begin
                req = full_q;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = data_q[src_q];
                out_src   = src_q;
            end
            default: begin
                req = 4'd0;
            end
        endcase
    end

    // Slots advertise free only outside reset.
    assign in_ready  = rst ? 4'd0 : ~full_q;
    assign err_grant = err_q;

    // ------------------------------------------------------------------
    // Slot and bookkeeping next-state
    // ------------------------------------------------------------------
    assign load = in_valid & in_ready;
    assign hs   = (state_q == ST_SEND) && out_ready;

    // A slot is never loaded while full, so the SEND payload cannot
    // change under an outstanding out_valid.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            full_d[i] = full_q[i];
            if (load[i]) begin
                data_d[i] = in_data[i*DATA_W +: DATA_W];
                full_d[i] = 1'b1;
            end
            if (hs && (src_q == 2'(i))) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        src_d = src_q;
        if (in_arb && g_legal) begin
            src_d = g_idx;
        end
    end

    always_comb begin
        err_d = err_q;
        if (in_arb && !g_zero && !g_legal) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            full_q  <= 4'd0;
            src_q   <= 2'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            src_q   <= src_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional per-client handshake counters
    // ------------------------------------------------------------------
`ifdef RR_MUX_CNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Saturate at 255 instead of wrapping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hs && (src_q == 2'(i)) && (cnt_q[i] != 8'hff)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
    assign grant_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rr_grant_mux.sv
// tb_rr_grant_mux: directed bench for rr_grant_mux with a registered
// round-robin arbiter model or manually driven grants.

module tb_rr_grant_mux;

    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = 4'd0;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready = 1'b0;
    logic        err_grant;
    logic [31:0] grant_cnt;

    logic        arb_auto = 1'b0;
    logic [3:0]  grant_man = 4'd0;
    logic [3:0]  arb_q = 4'd0;
    logic [1:0]  arb_ptr = 2'd0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_grant_mux #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .err_grant (err_grant),
        .grant_cnt (grant_cnt)
    );

    assign grant = arb_auto ? arb_q : grant_man;

    function automatic logic [3:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p);
        logic [3:0] g;
        logic [1:0] j;
        g = 4'd0;
        for (int k = 0; k < 4; k++) begin
            j = p + 2'(k);
            if (g == 4'd0 && r[j]) g[j] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (g[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Registered arbiter: the pointer moves past a grant once presented.
    always @(posedge clk) begin
        arb_q <= rr_pick(req, arb_ptr);
        if (arb_q != 4'd0) arb_ptr <= oh_idx(arb_q) + 2'd1;
    end

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int w;
        int hs_n;
        int lim;
        int rc [4];
        logic [1:0] rs [4];
        logic [7:0] rd [4];
        logic stale;
        logic [31:0] exp_cnt;

        for (int k = 0; k < 4; k++) begin
            rc[k] = -1;
            rs[k] = 2'd0;
            rd[k] = 8'd0;
        end

        // Reset defaults
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_req", 32'(req), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_src", 32'(out_src), 32'h0);
        check_eq("rst_err", 32'(err_grant), 32'h0);
        check_eq("rst_cnt", grant_cnt, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'hf);
        @(negedge clk);

        // Full rotation
        arb_auto  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h43322110;
        in_valid  = 4'hf;
        @(negedge clk);
        in_valid = 4'h0;
        check_eq("rot_req_c1", 32'(req), 32'hf);
        check_eq("rot_ov_c1", 32'(out_valid), 32'h0);
        @(negedge clk);
        check_eq("rot_grant_c2", 32'(grant), 32'h1);
        check_eq("rot_ov_c2", 32'(out_valid), 32'h0);
        @(negedge clk);
        n   = 0;
        cyc = 3;
        while (n < 4 && cyc < 40) begin
            if (out_valid) begin
                rs[n] = out_src;
                rd[n] = out_data;
                rc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("rot_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rot_src%0d", k), 32'(rs[k]), 32'(k));
            check_eq($sformatf("rot_data%0d", k), 32'(rd[k]),
                     32'h10 + 32'(k) * 32'h11);
            check_eq($sformatf("rot_cyc%0d", k), 32'(rc[k]),
                     32'(3 + 3 * k));
        end
        check_eq("rot_in_ready", 32'(in_ready), 32'hf);

        // Backpressure
        out_ready = 1'b0;
        in_data   = 32'h00a50000;
        in_valid  = 4'b0100;
        @(negedge clk);
        in_valid = 4'h0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_valid", 32'(out_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_ov", 32'(out_valid), 32'h1);
            check_eq("bp_data", 32'(out_data), 32'ha5);
            check_eq("bp_src", 32'(out_src), 32'h2);
            check_eq("bp_req", 32'(req), 32'h0);
            check_eq("bp_full", 32'(in_ready), 32'hb);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_done_ov", 32'(out_valid), 32'h0);
        check_eq("bp_done_rdy", 32'(in_ready), 32'hf);

        // Illegal grants
        arb_auto  = 1'b0;
        grant_man = 4'd0;
        in_data   = 32'h00005c00;
        in_valid  = 4'b0010;
        @(negedge clk);
        in_valid  = 4'h0;
        grant_man = 4'b0011;
        @(negedge clk);
        check_eq("ill_mh_err", 32'(err_grant), 32'h1);
        check_eq("ill_mh_ov", 32'(out_valid), 32'h0);
        grant_man = 4'b0100;
        @(negedge clk);
        check_eq("ill_empty_err", 32'(err_grant), 32'h1);
        check_eq("ill_empty_ov", 32'(out_valid), 32'h0);
        check_eq("ill_full", 32'(in_ready), 32'hd);
        check_eq("ill_req", 32'(req), 32'h2);
        grant_man = 4'b0010;
        @(negedge clk);
        check_eq("ill_ok_ov", 32'(out_valid), 32'h1);
        check_eq("ill_ok_src", 32'(out_src), 32'h1);
        check_eq("ill_ok_data", 32'(out_data), 32'h5c);
        grant_man = 4'd0;
        @(negedge clk);
        check_eq("ill_end_ov", 32'(out_valid), 32'h0);
        check_eq("ill_sticky", 32'(err_grant), 32'h1);
        check_eq("ill_end_rdy", 32'(in_ready), 32'hf);

        // Mid-transfer reset
        out_ready = 1'b0;
        in_data   = 32'h00000077;
        in_valid  = 4'b0001;
        @(negedge clk);
        in_valid  = 4'h0;
        grant_man = 4'b0001;
        @(negedge clk);
        grant_man = 4'd0;
        check_eq("mr_ov_pre", 32'(out_valid), 32'h1);
        check_eq("mr_data_pre", 32'(out_data), 32'h77);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mr_ov", 32'(out_valid), 32'h0);
        check_eq("mr_data", 32'(out_data), 32'h0);
        check_eq("mr_err", 32'(err_grant), 32'h0);
        check_eq("mr_in_ready", 32'(in_ready), 32'h0);
        check_eq("mr_req", 32'(req), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        arb_auto  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("mr_rel_rdy", 32'(in_ready), 32'hf);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || req != 4'd0) stale = 1'b1;
        end
        check_eq("mr_stale", 32'(stale), 32'h0);

        // Counter saturation
`ifdef RR_MUX_CNT_EN
        lim     = 300;
        exp_cnt = 32'hff000000;
`else
        lim     = 5;
        exp_cnt = 32'h0;
`endif
        in_data  = 32'hc3000000;
        in_valid = 4'b1000;
        hs_n = 0;
        w    = 0;
        while (hs_n < lim && w < lim * 8) begin
            @(negedge clk);
            w++;
            if (out_valid && out_ready) hs_n++;
        end
        in_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check_eq("cnt_hs", 32'(hs_n), 32'(lim));
        check_eq("cnt_val", grant_cnt, exp_cnt);
        check_eq("cnt_err", 32'(err_grant), 32'h0);
        check_eq("cnt_idle", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_grant_mux.md
# rr_grant_mux

Four-client request front-end and data multiplexer for the round-robin arbiter. Each client hands one transaction into a private holding slot over a valid/ready handshake. The block drives the arbiter's `req[3:0]` from the occupied slots and consumes the arbiter's one-hot `grant[3:0]`. The granted slot's data is forwarded to a single shared output channel with valid/ready flow control.

## Interface
Parameters:
- `DATA_W`, default 8: payload width per client.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  4  per-client transaction valid.
- `in_data`  in  4*DATA_W  per-client payload; client i occupies bits `[i*DATA_W +: DATA_W]`.
- `in_ready`  out  4  per-client slot free.
- `req`  out  4  request vector to the arbiter.
- `grant`  in  4  one-hot grant from the arbiter.
- `out_valid`  out  1  output transaction valid.
- `out_data`  out  DATA_W  payload of the granted client.
- `out_src`  out  2  index of the granted client.
- `out_ready`  in  1  downstream accept.
- `err_grant`  out  1  sticky flag for an illegal grant.
- `grant_cnt`  out  32  per-client 8-bit grant counters; client i occupies `[i*8 +: 8]`. Exists only when `RR_MUX_CNT_EN` is defined; see Configuration.

## Operation
- **Slots:** four 1-deep slots, each holding `full[i]` and `data[i]`.
  - `in_ready[i] = ~full[i]`.
  - When `in_valid[i] & in_ready[i]`, the slot loads and `full[i]` is set on the next edge.
  - A slot does not refill in the cycle it is emptied; `in_ready` rises one cycle after the slot empties.
- **FSM state ARB:**
  - `req = full`.
  - Each cycle, sample `grant`.
  - If `grant` is one-hot and `grant & full` is nonzero: latch the granted index into `src`, go to SEND.
  - If `grant == 0`: stay in ARB.
  - Otherwise (`grant` is multi-hot, or it points to an empty slot): set `err_grant`, ignore the grant, stay in ARB.
- **FSM state SEND:**
  - `req = 0`, which freezes the arbiter.
  - `out_valid = 1`, `out_data = data[src]`, `out_src = src`.
  - On `out_ready`: clear `full[src]`, return to ARB.
  - `grant` is ignored while in SEND.
- **Output stability:** while `out_valid` is high, `out_data` and `out_src` are held stable until the handshake completes.
- **err_grant:** sticky; only `rst` clears it.

## Timing
- **Reset values:**
  - `in_ready = 0` while `rst` is high, and `4'b1111` from the first cycle after release.
  - `req = 0`, `out_valid = 0`, `out_data = 0`, `out_src = 0`, `err_grant = 0`, `grant_cnt = 0`.
  - All slots empty; FSM in ARB.
- **Latency to output**, for a registered-grant arbiter and an idle block:
  - Accept at edge 0.
  - `req` high in cycle 1.
  - `grant` seen in cycle 2.
  - `out_valid` high in cycle 3.
- **Back-to-back transfers:** after the output handshake at edge t, the FSM is in ARB in cycle t+1. That cycle's `grant` reflects `req = 0`, so it is 0. The next transfer's `out_valid` is high no earlier than cycle t+3.
- **Simultaneous events:**
  - A new `in_valid` on another client during SEND is accepted into its slot normally.
  - `out_ready` held high continuously is allowed.
  - `out_ready` while `out_valid` is low has no effect.
- **Reset mid-operation:** `rst` asserted asynchronously drops all held transactions, including one in SEND, and returns every output to its reset value immediately.

## Configuration
- **`RR_MUX_CNT_EN` defined:**
  - `grant_cnt[i]` increments on each completed output handshake from client i.
  - Each counter saturates at 255 and never wraps.
  - Counters are cleared by `rst`.
- **`RR_MUX_CNT_EN` undefined:**
  - No counter logic is built.
  - `grant_cnt` is tied to 0.

## Test plan
- **Reset defaults:** `rst` pulsed mid-cycle -> all outputs take reset values asynchronously; `in_ready = 4'b1111` after release.
- **Full rotation:** all four clients present data `0x10`, `0x21`, `0x32`, `0x43` once; `out_ready = 1` -> four outputs, `out_src` following the arbiter rotation 0,1,2,3, each carrying its client's data; every `in_ready` returns to 1.
- **Backpressure:** client 2 sends `0xA5`; `out_ready = 0` for 5 cycles -> `out_valid`, `out_data = 0xA5` and `out_src = 2` stable throughout; `req = 0`; the slot stays full; the transfer completes on the first `out_ready`.
- **Illegal grants:** with only slot 1 full, drive `grant = 4'b0011` and then `4'b0100` -> `err_grant` set and sticky, no output, slot 1 still full; a following `grant = 4'b0010` completes the transfer.
- **Mid-transfer reset:** `rst` asserted during SEND -> `out_valid` drops immediately, all slots are empty after release, and no stale output appears.
- **Counter saturation (`RR_MUX_CNT_EN` only):** 300 transfers from client 3 -> `grant_cnt[31:24] = 255`; other counters stay 0. Without the macro, `grant_cnt` is 0 throughout.
